// File: rtl/shift_rgst_seq.sv
// rtl/shift_rgst_seq.sv - SRT4 working register with shifts and a start/busy/done repeat sequencer
// Supports load, clear and clamped left/right shifts. A repeated op runs from latched op/k.

module shift_rgst_seq #(
   parameter int W    = 8,
   parameter int KMAX = 2,
   parameter int CNTW = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        ld,
   input  logic [W-1:0]                d,
   input  logic [1:0]                  op,
   input  logic [$clog2(KMAX+1)-1:0]   k,
   input  logic [KMAX-1:0]             sin,
   input  logic                        start,
   input  logic [CNTW-1:0]             nshift,
   output logic [W-1:0]                q,
   output logic [KMAX-1:0]             sout,
   output logic                        busy,
   output logic                        done
);

   localparam int KW = $clog2(KMAX+1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [CNTW-1:0] cnt, cnt_n;
   logic [1:0]      lop, lop_n;
   logic [KW-1:0]   lk, lk_n;
   logic [W-1:0]    q_n;
   logic [KMAX-1:0] sout_n;

   logic [1:0]      s_op;
   logic [KW-1:0]   s_k;
   logic [KW-1:0]   kk;
   logic [W-1:0]    mask;
   logic [W-1:0]    sin_ext;
   logic [W-1:0]    fill;
   logic [W-1:0]    sh_q;
   logic [KMAX-1:0] sh_sout;
   logic            sh_act;

   // One shared shifter: live op/k in IDLE, latched copies while running.
   always_comb begin
      s_op    = (state == RUN) ? lop : op;
      s_k     = (state == RUN) ? lk  : k;
      kk      = (s_k > KW'(KMAX)) ? KW'(KMAX) : s_k;
      mask    = (W'(1) << kk) - W'(1);
      sin_ext = W'(sin) & mask;
      fill    = '0;
      sh_q    = q;
      sh_sout = sout;
      sh_act  = (s_op != 2'b00) && (kk != '0);
      case (s_op)
         2'b01: begin
            sh_q    = (q << kk) | sin_ext;
            sh_sout = KMAX'(q >> (W - int'(kk)));
         end
         2'b10, 2'b11: begin
            fill    = s_op[0] ? (q[W-1] ? mask : '0) : sin_ext;
            sh_q    = (q >> kk) | (fill << (W - int'(kk)));
            sh_sout = KMAX'(q & mask);
         end
         default: begin
            sh_q    = q;
            sh_sout = sout;
         end
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lop_n   = lop;
      lk_n    = lk;
      q_n     = q;
      sout_n  = sout;
      case (state)
         IDLE: begin
            if (ld) begin
               q_n = d;
            end else if (start) begin
               if (nshift != '0) begin
                  lop_n   = op;
                  lk_n    = k;
                  cnt_n   = nshift;
                  state_n = RUN;
               end else begin
                  state_n = DONE;
               end
            end else if (sh_act) begin
               q_n    = sh_q;
               sout_n = sh_sout;
            end
         end
         RUN: begin
            if (sh_act) begin
               q_n    = sh_q;
               sout_n = sh_sout;
            end
            cnt_n = cnt - CNTW'(1);
            if (cnt == CNTW'(1)) begin
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      if (clr) begin
         q_n     = '0;
         sout_n  = '0;
         cnt_n   = '0;
         state_n = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         lop   <= 2'b00;
         lk    <= '0;
         q     <= '0;
         sout  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         lop   <= lop_n;
         lk    <= lk_n;
         q     <= q_n;
         sout  <= sout_n;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_shift_rgst_seq.sv
// tb/tb_shift_rgst_seq.sv - directed and random checks of shift_rgst_seq against an arithmetic model
// The model tracks remaining shifts and a done flag rather than FSM states.

module tb_shift_rgst_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       ld = 1'b0;
   logic [7:0] d = 8'h00;
   logic [1:0] op = 2'b00;
   logic [1:0] k = 2'd0;
   logic [1:0] sin = 2'b00;
   logic       start = 1'b0;
   logic [3:0] nshift = 4'd0;
   logic [7:0] q;
   logic [1:0] sout;
   logic       busy;
   logic       done;

   int vectors = 0;
   int errors  = 0;

   int m_q = 0, m_sout = 0, m_rem = 0, m_done = 0, m_op = 0, m_k = 0;

   shift_rgst_seq #(.W(8), .KMAX(2), .CNTW(4)) dut (
      .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .op(op), .k(k),
      .sin(sin), .start(start), .nshift(nshift),
      .q(q), .sout(sout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Shift applied to the model register with plain integer arithmetic.
   task automatic model_shift(input int sop, input int sk, input int ssin);
      int kk, p, fillv;
      kk = (sk > 2) ? 2 : sk;
      p  = 1 << kk;
      if (sop == 0 || kk == 0) return;
      if (sop == 1) begin
         m_sout = m_q / (256 / p);
         m_q    = (m_q * p) % 256 + ssin % p;
      end else begin
         m_sout = m_q % p;
         if (sop == 3) fillv = (m_q >= 128) ? p - 1 : 0;
         else          fillv = ssin % p;
         m_q = m_q / p + fillv * (256 / p);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_q = 0; m_sout = 0; m_rem = 0; m_done = 0;
      end else if (clr) begin
         m_q = 0; m_sout = 0; m_rem = 0; m_done = 0;
      end else if (m_done != 0) begin
         m_done = 0;
      end else if (m_rem > 0) begin
         model_shift(m_op, m_k, int'(sin));
         m_rem--;
         if (m_rem == 0) m_done = 1;
      end else if (ld) begin
         m_q = int'(d);
      end else if (start) begin
         if (nshift == 0) m_done = 1;
         else begin
            m_rem = int'(nshift);
            m_op  = int'(op);
            m_k   = int'(k);
         end
      end else begin
         model_shift(int'(op), int'(k), int'(sin));
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("q", 32'(q), 32'(m_q));
      chk("sout", 32'(sout), 32'(m_sout));
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("done", 32'(done), 32'(m_done));
   endtask

   task automatic idle_inputs();
      rst = 1'b0; clr = 1'b0; ld = 1'b0; start = 1'b0; op = 2'b00;
   endtask

   initial begin
      // 1: reset
      rst = 1'b1;
      step();
      step();
      chk("reset_q", 32'(q), 32'h0);
      idle_inputs();

      // 2: load then shl by 1
      ld = 1'b1; d = 8'hA5; step();
      ld = 1'b0; op = 2'b01; k = 2'd1; sin = 2'b01; step();
      chk("shl_q", 32'(q), 32'h4B);
      chk("shl_sout", 32'(sout), 32'h1);

      // 3: arithmetic then clamped logical right
      op = 2'b00; ld = 1'b1; d = 8'h90; step();
      ld = 1'b0; op = 2'b11; k = 2'd2; step();
      chk("sra_q", 32'(q), 32'hE4);
      op = 2'b10; k = 2'd3; sin = 2'b10; step();
      chk("srl_clamp_q", 32'(q), 32'hB9);
      chk("srl_clamp_sout", 32'(sout), 32'h0);

      // 4: repeated shl by 2, three times
      op = 2'b00; ld = 1'b1; d = 8'h01; step();
      ld = 1'b0; start = 1'b1; op = 2'b01; k = 2'd2; nshift = 4'd3; sin = 2'b00; step();
      start = 1'b0; op = 2'b00; k = 2'd0;
      step(); chk("seq_q1", 32'(q), 32'h04);
      step(); chk("seq_q2", 32'(q), 32'h10);
      step(); chk("seq_q3", 32'(q), 32'h40);
      chk("seq_done", 32'(done), 32'h1);
      step(); chk("seq_done_drop", 32'(done), 32'h0);

      // 5: ld ignored while busy, clr aborts without done
      ld = 1'b1; d = 8'h01; step();
      ld = 1'b0; start = 1'b1; op = 2'b01; k = 2'd1; nshift = 4'd4; step();
      start = 1'b0; ld = 1'b1; d = 8'hFF; step();
      ld = 1'b0; step();
      chk("abort_pre_q", 32'(q), 32'h04);
      clr = 1'b1; step();
      clr = 1'b0; chk("abort_busy", 32'(busy), 32'h0);
      step(); chk("abort_no_done", 32'(done), 32'h0);

      // 6: zero-length sequence, then reset mid-run
      ld = 1'b1; d = 8'h3C; step();
      ld = 1'b0; start = 1'b1; nshift = 4'd0; step();
      start = 1'b0; chk("zero_done", 32'(done), 32'h1);
      chk("zero_q", 32'(q), 32'h3C);
      step();
      start = 1'b1; op = 2'b10; k = 2'd1; nshift = 4'd6; step();
      start = 1'b0; step();
      rst = 1'b1; step();
      rst = 1'b0;
      chk("rst_mid_q", 32'(q), 32'h0);
      chk("rst_mid_busy", 32'(busy), 32'h0);

      // random phase
      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(0, 99) == 0);
         clr    = ($urandom_range(0, 49) == 0);
         ld     = ($urandom_range(0, 7) == 0);
         start  = ($urandom_range(0, 5) == 0);
         d      = 8'($urandom);
         op     = 2'($urandom);
         k      = 2'($urandom);
         sin    = 2'($urandom);
         nshift = 4'($urandom_range(0, 6));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
